mem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data memory between two requesters: the instruction-fetch path (IF) and the load/store data path (D).
- Replaces the fixed FETCH/MEM_DELAY wait states in the main control FSM with a request/grant/done handshake.
- Hides the memory latency behind a counted access window.
- Sits between the Control FSM and the memory, and drives the memory address, write-enable and write-data pins.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_wait_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam int MEM_LATENCY_DEFAULT = 3;

    // Wait-counter width: enough to hold MEM_LATENCY-1, never narrower than 1 bit.
    function automatic int wait_cnt_width(input int latency);
        if (latency <= 2) begin
            return 1;
        end
        return $clog2(latency);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the memory access window.
// It stops at zero; tc is high whenever the count is zero.
module mem_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Load takes precedence over decrement; saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between the fetch (IF) and data (D)
// requesters with a request/grant/done handshake and a counted access window.
//
// State table:
//   ARB_IDLE   | no owner; sample requests and pick an owner
//   ARB_ACCESS | owner's address/wr/wdata driven to memory for MEM_LATENCY cycles
//   ARB_DONE   | write enable dropped, owner's done pulses, read data captured
//
// Build option: define MEM_ARB_RR_EN to make ties alternate between the two
// requesters (round robin); otherwise D always wins a tie.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset_signal,
    input  logic              If_req,
    input  logic [ADDR_W-1:0] If_addr,
    output logic              If_gnt,
    output logic              If_done,
    output logic [DATA_W-1:0] If_rdata,
    input  logic              D_req,
    input  logic              D_wr,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic              D_gnt,
    output logic              D_done,
    output logic [DATA_W-1:0] D_rdata,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_wr,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic              Busy,
    output logic [1:0]        StateOut
);

    localparam int              CNT_W    = wait_cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_owner_t        owner;
    arb_owner_t        sel_owner;
    logic              start;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_tc;
    logic              in_access;
    logic              in_done;

    assign start     = (state == ARB_IDLE) && (If_req || D_req);
    assign in_access = (state == ARB_ACCESS);
    assign in_done   = (state == ARB_DONE);

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_owner;

    // Remember who was granted most recently so the other side wins the next tie.
    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            last_owner <= OWN_D;
        end else if (start) begin
            last_owner <= sel_owner;
        end
    end

    // Round-robin owner selection; a lone requester always wins.
    always_comb begin
        sel_owner = OWN_IF;
        if (D_req && If_req) begin
            sel_owner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
        end else if (D_req) begin
            sel_owner = OWN_D;
        end
    end
`else
    // Fixed priority: D wins whenever it is requesting.
    always_comb begin
        sel_owner = OWN_IF;
        if (D_req) begin
            sel_owner = OWN_D;
        end
    end
`endif

    mem_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk      (Clk),
        .rst_n    (Reset_signal),
        .load     (start),
        .load_val (CNT_LOAD),
        .dec      (in_access),
        .count    (wait_cnt),
        .tc       (wait_tc)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (start) begin
                    state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (wait_tc) begin
                    state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Capture the winning requester's transaction at arbitration; fetches are reads
    // with no write data.
    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            owner     <= OWN_IF;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
        end else if (start) begin
            owner <= sel_owner;
            if (sel_owner == OWN_D) begin
                lat_addr  <= D_addr;
                lat_wr    <= D_wr;
                lat_wdata <= D_wdata;
            end else begin
                lat_addr  <= If_addr;
                lat_wr    <= 1'b0;
                lat_wdata <= '0;
            end
        end
    end

    // Read data is taken at the edge leaving DONE, into the owner's register only.
    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            If_rdata <= '0;
            D_rdata  <= '0;
        end else if (in_done && !lat_wr) begin
            if (owner == OWN_D) begin
                D_rdata <= Mem_rdata;
            end else begin
                If_rdata <= Mem_rdata;
            end
        end
    end

    // Memory pins, handshake and status outputs decoded from the registered state.
    always_comb begin
        Mem_addr  = '0;
        Mem_wdata = '0;
        Mem_wr    = 1'b0;
        If_gnt    = 1'b0;
        D_gnt     = 1'b0;
        If_done   = 1'b0;
        D_done    = 1'b0;
        if (in_access || in_done) begin
            Mem_addr  = lat_addr;
            Mem_wdata = lat_wdata;
            Mem_wr    = in_access && lat_wr;
            If_gnt    = (owner == OWN_IF);
            D_gnt     = (owner == OWN_D);
            If_done   = in_done && (owner == OWN_IF);
            D_done    = in_done && (owner == OWN_D);
        end
    end

    assign Busy     = (state != ARB_IDLE);
    assign StateOut = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, compared each cycle against a transaction-phase model.
// A second instance with MEM_LATENCY = 1 runs continuous fetches alongside.
module tb_mem_port_arbiter;

    localparam int ML = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset_signal;
    logic          If_req, D_req, D_wr;
    logic [AW-1:0] If_addr, D_addr;
    logic [DW-1:0] D_wdata, Mem_rdata;
    logic          If_gnt, If_done, D_gnt, D_done, Mem_wr, Busy;
    logic [DW-1:0] If_rdata, D_rdata, Mem_wdata;
    logic [AW-1:0] Mem_addr;
    logic [1:0]    StateOut;

    logic          q_if_gnt, q_if_done, q_d_gnt, q_d_done, q_mem_wr, q_busy;
    logic [DW-1:0] q_if_rdata, q_d_rdata, q_mem_wdata;
    logic [AW-1:0] q_mem_addr;
    logic [1:0]    q_state;
    logic          q_if_req;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int q_last_done = -1;
    int q_done_cnt  = 0;

    // Model: an access is a run of phases 1..ML (memory window) then ML+1 (done).
    bit            m_active;
    int            m_phase;
    bit            m_owner_d;
    bit            m_last_d;
    logic [AW-1:0] m_addr;
    bit            m_wr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_if_rdata, m_d_rdata;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML)) u_dut (
        .Clk(Clk), .Reset_signal(Reset_signal),
        .If_req(If_req), .If_addr(If_addr), .If_gnt(If_gnt), .If_done(If_done), .If_rdata(If_rdata),
        .D_req(D_req), .D_wr(D_wr), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_gnt(D_gnt), .D_done(D_done), .D_rdata(D_rdata),
        .Mem_addr(Mem_addr), .Mem_wr(Mem_wr), .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata),
        .Busy(Busy), .StateOut(StateOut)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut_l1 (
        .Clk(Clk), .Reset_signal(Reset_signal),
        .If_req(q_if_req), .If_addr(32'h0000_0080), .If_gnt(q_if_gnt), .If_done(q_if_done), .If_rdata(q_if_rdata),
        .D_req(1'b0), .D_wr(1'b0), .D_addr(32'h0), .D_wdata(32'h0),
        .D_gnt(q_d_gnt), .D_done(q_d_done), .D_rdata(q_d_rdata),
        .Mem_addr(q_mem_addr), .Mem_wr(q_mem_wr), .Mem_wdata(q_mem_wdata), .Mem_rdata(Mem_rdata),
        .Busy(q_busy), .StateOut(q_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_phase    = 0;
        m_owner_d  = 0;
        m_last_d   = 1;
        m_addr     = '0;
        m_wr       = 0;
        m_wdata    = '0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled.
    task automatic model_step();
        if (m_active) begin
            if (m_phase == ML + 1) begin
                if (!m_wr) begin
                    if (m_owner_d) m_d_rdata = Mem_rdata;
                    else           m_if_rdata = Mem_rdata;
                end
                m_active = 0;
            end else begin
                m_phase++;
            end
        end else if (If_req || D_req) begin
            if (If_req && D_req) begin
`ifdef MEM_ARB_RR_EN
                m_owner_d = !m_last_d;
`else
                m_owner_d = 1;
`endif
            end else begin
                m_owner_d = D_req;
            end
            m_last_d = m_owner_d;
            m_addr   = m_owner_d ? D_addr : If_addr;
            m_wr     = m_owner_d && D_wr;
            m_wdata  = m_owner_d ? D_wdata : '0;
            m_active = 1;
            m_phase  = 1;
        end
    endtask

    task automatic check_all();
        int  exp_state;
        bit  in_win;
        bit  in_done;
        in_win    = m_active && (m_phase <= ML);
        in_done   = m_active && (m_phase == ML + 1);
        exp_state = !m_active ? 0 : (in_win ? 1 : 2);
        check("state",     StateOut,  exp_state);
        check("busy",      Busy,      m_active);
        check("if_gnt",    If_gnt,    m_active && !m_owner_d);
        check("d_gnt",     D_gnt,     m_active && m_owner_d);
        check("if_done",   If_done,   in_done && !m_owner_d);
        check("d_done",    D_done,    in_done && m_owner_d);
        check("mem_addr",  Mem_addr,  m_active ? m_addr : '0);
        check("mem_wr",    Mem_wr,    in_win && m_wr);
        check("mem_wdata", Mem_wdata, m_active ? m_wdata : '0);
        check("if_rdata",  If_rdata,  m_if_rdata);
        check("d_rdata",   D_rdata,   m_d_rdata);
        check("l1_gnt_overlap", q_if_gnt && q_d_gnt, 1'b0);
        if (q_if_done) begin
            if (q_last_done >= 0) check("l1_done_period", cyc - q_last_done, 3);
            q_last_done = cyc;
            q_done_cnt++;
        end
    endtask

    // One clock: edge, model update, sample 1 time unit later, return at negedge.
    task automatic cycle();
        @(posedge Clk);
        cyc++;
        model_step();
        #1;
        check_all();
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        If_req = 0; D_req = 0; D_wr = 0;
        If_addr = '0; D_addr = '0; D_wdata = '0;
    endtask

    // Runs until the done of the given port (bounded); drops that port's req after grant.
    task automatic run_to_done(input bit port_d, output int done_at, output int wr_cycles);
        done_at   = 0;
        wr_cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (Mem_wr) wr_cycles++;
            if (i == 1) begin
                if (port_d) D_req = 0;
                else        If_req = 0;
            end
            if ((port_d && D_done) || (!port_d && If_done)) begin
                done_at = i;
                break;
            end
        end
    endtask

    initial begin
        int done_at;
        int wr_cycles;
        logic [DW-1:0] d_before;
        bit first_d;

        Reset_signal = 0;
        q_if_req     = 1;
        Mem_rdata    = '0;
        idle_inputs();
        model_reset();

        // Reset state
        #3;
        check_all();
        check("rst_state", StateOut, 2'd0);
        check("rst_busy",  Busy,     1'b0);
        @(negedge Clk);
        Reset_signal = 1;
        cycle();
        cycle();

        // Single fetch
        If_req = 1; If_addr = 32'h40; Mem_rdata = 32'h8C01_0004;
        run_to_done(0, done_at, wr_cycles);
        check("fetch_done_at",   done_at,   4);
        check("fetch_wr_cycles", wr_cycles, 0);
        cycle();
        check("fetch_rdata", If_rdata, 32'h8C01_0004);

        // Single store
        d_before = m_d_rdata;
        D_req = 1; D_wr = 1; D_addr = 32'h100; D_wdata = 32'hDEAD_BEEF; Mem_rdata = 32'h1234_5678;
        run_to_done(1, done_at, wr_cycles);
        check("store_done_at",   done_at,   4);
        check("store_wr_cycles", wr_cycles, 3);
        cycle();
        check("store_d_rdata", D_rdata, d_before);

        // Simultaneous requests: winner first, loser after one IDLE cycle
        D_wr = 0; D_addr = 32'h204; If_addr = 32'h44; Mem_rdata = 32'hA5A5_0001;
`ifdef MEM_ARB_RR_EN
        first_d = !m_last_d;
`else
        first_d = 1;
`endif
        If_req = 1; D_req = 1;
        cycle();
        check("tie_first_d_gnt", D_gnt, first_d);
        for (int i = 0; i < 12 && !(D_done || If_done); i++) cycle();
        if (first_d) D_req = 0; else If_req = 0;
        cycle();
        check("tie_idle_gap", Busy, 1'b0);
        Mem_rdata = 32'hA5A5_0002;
        cycle();
        check("tie_second_if_gnt", If_gnt, first_d);
        If_req = 0; D_req = 0;
        for (int i = 0; i < 12 && Busy; i++) cycle();

        // Reset during the second access cycle
        D_req = 1; D_wr = 1; D_addr = 32'h300; D_wdata = 32'h0BAD_F00D;
        cycle();
        D_req = 0;
        cycle();
        check("pre_rst_mem_wr", Mem_wr, 1'b1);
        Reset_signal = 0;
        #1;
        model_reset();
        q_last_done = -1;
        check("rst_mem_wr", Mem_wr,   1'b0);
        check("rst_state2", StateOut, 2'd0);
        check("rst_busy2",  Busy,     1'b0);
        @(posedge Clk);
        #1;
        check("rst_no_done", D_done, 1'b0);
        @(negedge Clk);
        Reset_signal = 1;
        If_req = 1; If_addr = 32'h48; Mem_rdata = 32'h0000_BEEF;
        run_to_done(0, done_at, wr_cycles);
        check("post_rst_done_at", done_at, 4);
        cycle();
        check("post_rst_rdata", If_rdata, 32'h0000_BEEF);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            If_req    = ($urandom_range(0, 2) != 0);
            D_req     = ($urandom_range(0, 2) == 0);
            D_wr      = $urandom_range(0, 1);
            If_addr   = $urandom;
            D_addr    = $urandom;
            D_wdata   = $urandom;
            Mem_rdata = $urandom;
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) cycle();

        check("l1_done_seen", q_done_cnt > 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
